// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Programmable clock divider with period-aligned ratio changes.
// Revision : 1.0
// ============================================================================
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_applied,
    output logic             cfg_err,
    output logic             div_out,
    output logic             div_tick,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nx;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] cur_div_nx;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_div_nx;
    logic             div_out_nx;
    logic             div_tick_nx;
    logic             applied_nx;
    logic             err_nx;
    logic             hs;
    logic             hs_ok;
    logic             last;

    assign cfg_ready = (state != S_PEND);
    assign running   = (state != S_IDLE);

    assign hs        = cfg_valid && cfg_ready;
    assign hs_ok     = hs && (cfg_div >= WIDTH'(2));
    assign last      = (count == cur_div - 1'b1);
    assign count_inc = count + 1'b1;

    // Outputs are computed for the cycle being entered so div_out, div_tick
    // and cfg_applied all come straight out of flops.
    always_comb begin
        state_nx    = state;
        count_nx    = count;
        cur_div_nx  = cur_div;
        pend_div_nx = pend_div;
        div_out_nx  = 1'b0;
        div_tick_nx = 1'b0;
        applied_nx  = 1'b0;
        err_nx      = hs && !hs_ok;

        case (state)
            S_IDLE: begin
                count_nx = '0;
                if (hs_ok) begin
                    cur_div_nx = cfg_div;
                    applied_nx = 1'b1;
                end
                if (enable) begin
                    state_nx   = S_RUN;
                    div_out_nx = 1'b1;
                end
            end
            S_RUN, S_PEND: begin
                if (last) begin
                    // Period boundary: the only point where the ratio may change.
                    if (state == S_PEND) begin
                        cur_div_nx = pend_div;
                        applied_nx = 1'b1;
                    end else if (hs_ok) begin
                        cur_div_nx  = cfg_div;
                        pend_div_nx = cfg_div;
                        applied_nx  = 1'b1;
                    end
                    count_nx = '0;
                    if (enable) begin
                        state_nx   = S_RUN;
                        div_out_nx = 1'b1;
                    end else begin
                        state_nx   = S_IDLE;
                    end
                end else begin
                    count_nx    = count_inc;
                    div_out_nx  = (count_inc < (cur_div >> 1));
                    div_tick_nx = (count_inc == cur_div - 1'b1);
                    if ((state == S_RUN) && hs_ok) begin
                        pend_div_nx = cfg_div;
                        state_nx    = S_PEND;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                count_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            cur_div     <= WIDTH'(DEFAULT_DIV);
            pend_div    <= '0;
            div_out     <= 1'b0;
            div_tick    <= 1'b0;
            cfg_applied <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            cur_div     <= cur_div_nx;
            pend_div    <= pend_div_nx;
            div_out     <= div_out_nx;
            div_tick    <= div_tick_nx;
            cfg_applied <= applied_nx;
            cfg_err     <= err_nx;
        end
    end

endmodule
`default_nettype wire
